// File: rtl/uart_rx_packer.sv
// 8N1 UART receiver that packs DATA_WIDTH/8 consecutive bytes into a little-endian word.
// Optional inter-byte timeout when UART_RX_TIMEOUT_EN is defined.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | line idle, waiting for a falling edge on rxd_s
//   ST_START     | half-bit wait, confirm start bit still low
//   ST_DATA      | sample 8 data bits, one per bit period, LSB first
//   ST_STOP      | one bit period, then check stop bit
//   ST_WAIT_HIGH | framing error seen, wait for line to return high
module uart_rx_packer #(
   parameter int CLK_FREQ   = 200000000,
   parameter int UART_BPS   = 9600,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  uart_rxd,
   output logic [DATA_WIDTH-1:0] word_data,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
   localparam int HALF_CNT = BAUD_CNT / 2;
   localparam int NBYTES   = DATA_WIDTH / 8;
   localparam int CNT_W    = $clog2(BAUD_CNT + 1);
   localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CNT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   state_t                state_q, state_d;
   logic                  rxd_m, rxd_s, rxd_prev;
   logic                  fall;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  tc;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shift_q, shift_d;
   logic                  start_ok, byte_ok, stop_bad;
   logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
   logic [DATA_WIDTH-1:0] pack_q, word_asm;
   logic                  word_done;

   assign fall = rxd_prev & ~rxd_s;

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_CNT = 20 * BAUD_CNT;
   localparam int TO_W   = $clog2(TO_CNT + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_CNT - 1);

   logic [TO_W-1:0] to_cnt_q;
   logic            to_active_q;
   logic            to_expire;

   assign to_expire = to_active_q && (to_cnt_q == '0) && (byte_idx_q != '0);

   // Restarted by every accepted byte, parked once a confirmed start bit arrives.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         to_cnt_q    <= '0;
         to_active_q <= 1'b0;
      end else if (byte_ok) begin
         to_cnt_q    <= TO_LOAD;
         to_active_q <= 1'b1;
      end else if (start_ok || to_expire) begin
         to_active_q <= 1'b0;
      end else if (to_active_q && (to_cnt_q != '0)) begin
         to_cnt_q <= to_cnt_q - 1'b1;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      start_ok = 1'b0;
      byte_ok  = 1'b0;
      stop_bad = 1'b0;
      tc       = (cnt_q == '0);
      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d = ST_START;
               cnt_d   = HALF_LOAD;
               bit_d   = '0;
            end
         end
         ST_START: begin
            if (!tc) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!rxd_s) begin
               state_d  = ST_DATA;
               cnt_d    = BAUD_LOAD;
               start_ok = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!tc) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d = {rxd_s, shift_q[7:1]};
               cnt_d   = BAUD_LOAD;
               if (bit_q == 3'd7) state_d = ST_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         ST_STOP: begin
            if (!tc) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxd_s) begin
               byte_ok = 1'b1;
               state_d = ST_IDLE;
            end else begin
               stop_bad = 1'b1;
               state_d  = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (rxd_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The completed word is assembled combinationally so it can be loaded on the stop-sample edge.
   always_comb begin
      word_asm = pack_q;
      word_asm[{byte_idx_q, 3'b000} +: 8] = shift_q;
      word_done  = byte_ok && (byte_idx_q == LAST_IDX);
      byte_idx_d = byte_idx_q;
      if (byte_ok) begin
         byte_idx_d = word_done ? '0 : byte_idx_q + 1'b1;
      end
`ifdef UART_RX_TIMEOUT_EN
      else if (to_expire) begin
         byte_idx_d = '0;
      end
`endif
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rxd_m      <= 1'b1;
         rxd_s      <= 1'b1;
         rxd_prev   <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_idx_q <= '0;
         pack_q     <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rxd_m      <= uart_rxd;
         rxd_s      <= rxd_m;
         rxd_prev   <= rxd_s;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         if (byte_ok) pack_q <= word_asm;
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (word_done) begin
            if (!word_valid || word_ready) begin
               word_data  <= word_asm;
               word_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_packer.md
# uart_rx_packer

UART receive front end for the UART debug path: oversamples `uart_rxd` (8N1, LSB first), recovers bytes and packs `DATA_WIDTH/8` consecutive bytes into one word. The word goes out over a valid/ready handshake. The block sits directly upstream of the word FIFO in the UART top level, driven from the 200 MHz `sys_clk`. It reports framing errors and output overruns as single-cycle pulses.

## Interface
- `CLK_FREQ`, 200000000: `sys_clk` frequency in Hz.
- `UART_BPS`, 9600: baud rate. `BAUD_CNT = CLK_FREQ/UART_BPS` (integer division; 20833 at defaults).
- `DATA_WIDTH`, 32: output word width. Must be a multiple of 8 and ≥ 8. `NBYTES = DATA_WIDTH/8`.

Ports:
- `sys_clk` in 1: the single clock; all logic is on its rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `uart_rxd` in 1: asynchronous serial input, idle high.
- `word_data` out `DATA_WIDTH`: packed word. The first received byte is in `[7:0]` (little-endian).
- `word_valid` out 1: `word_data` holds an unconsumed word.
- `word_ready` in 1: consumer accepts the word when both `word_valid` and `word_ready` are high.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.

## Operation
- Input synchronizer:
  - Two flops on `uart_rxd`, both reset to 1.
  - All decisions use the second-stage output `rxd_s`.
  - Falling edge = previous `rxd_s` is 1 and current `rxd_s` is 0.
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a falling edge moves to START and clears the bit counter.
  - START: counts `BAUD_CNT/2` cycles. At the terminal count, `rxd_s`=0 moves to DATA; `rxd_s`=1 is a glitch and returns to IDLE with no output.
  - DATA: counts `BAUD_CNT` cycles per bit and samples `rxd_s` at each terminal count into the shift register, LSB first. After bit 7, moves to STOP.
  - STOP: counts `BAUD_CNT` cycles, then samples.
    - Sample 1: byte accepted, return to IDLE.
    - Sample 0: `frame_err` pulses, byte discarded (byte index unchanged), move to WAIT_HIGH.
  - WAIT_HIGH: stays until `rxd_s`=1, then moves to IDLE. A break condition never produces bytes.
- Packing:
  - An accepted byte is written to lane `byte_idx`, then `byte_idx` increments.
  - When the byte written is lane `NBYTES-1`, the assembled word is complete and `byte_idx` wraps to 0.
- Output register, evaluated on the cycle a word completes:
  - `word_valid`=0: load `word_data` and set `word_valid`.
  - `word_valid`=1 and `word_ready`=1 in the same cycle: load the new word and keep `word_valid`=1. No overrun.
  - `word_valid`=1 and `word_ready`=0: the new word is dropped, `overrun` pulses, and `word_data` is unchanged.
  - On a cycle with no completion, `word_valid & word_ready` clears `word_valid`. `word_data` holds its last value.
- Handshake: `word_data` is stable while `word_valid`=1 and not yet accepted. `word_valid` does not depend combinationally on `word_ready`.

## Timing
- Reset values:
  - Outputs: `word_data`=0, `word_valid`=0, `frame_err`=0, `overrun`=0.
  - Internal: FSM in IDLE, `byte_idx`=0, counters 0, synchronizer flops 1.
- Reset mid-frame or mid-word discards everything, including any partial word.
- Sample instants:
  - Input to detection: 2-cycle synchronizer delay.
  - Data bit k is sampled `BAUD_CNT/2 + (k+1)*BAUD_CNT` cycles after the detected falling edge.
  - The stop bit is sampled `BAUD_CNT/2 + 9*BAUD_CNT` cycles after the detected falling edge.
- Latencies:
  - `word_valid` rises 1 cycle after the stop-bit sample of the last byte of a word.
  - `frame_err` and `overrun` are asserted in the cycle after the triggering sample, for exactly 1 cycle.
- Throughput: back-to-back frames with a 1-bit stop are supported. After the stop sample the FSM is back in IDLE, mid-stop-bit, ready for the next falling edge.

## Configuration
- `UART_RX_TIMEOUT_EN` defined: inter-byte timeout.
  - A counter restarts at each accepted byte.
  - If `byte_idx` ≠ 0 and no new start bit is detected within `20*BAUD_CNT` cycles, the partial word is discarded and `byte_idx` returns to 0.
  - No pulse is generated for the discard.
  - A start bit detected before expiry stops the counter.
- `UART_RX_TIMEOUT_EN` undefined: no timeout logic. Partial words wait indefinitely for their remaining bytes.

## Test plan
Bench parameters: CLK_FREQ=1000000, UART_BPS=100000 (`BAUD_CNT`=10), DATA_WIDTH=32.

- Four frames 0x78, 0x56, 0x34, 0x12 with `word_ready`=0 -> `word_data`=0x12345678. `word_valid` stays high until `word_ready`=1 for one cycle, then clears.
- 3-cycle low glitch on an idle line -> no `frame_err`, no byte; the next four frames pack correctly.
- Frame 0xA5 with stop bit driven 0 -> exactly one `frame_err` pulse. Line released high, then 0x01, 0x02, 0x03, 0x04 -> `word_data`=0x04030201.
- `word_ready`=0, eight frames 0x00–0x07 -> first word 0x03020100 held, one `overrun` pulse at the second completion, `word_data` unchanged.
- `word_ready` tied 1, eight back-to-back frames -> two one-cycle `word_valid` pulses with 0x03020100 then 0x07060504, no `overrun`.
- Two frames 0xAA, 0xBB, then idle for 25 bit times, then 0x11, 0x22, 0x33, 0x44:
  - With `UART_RX_TIMEOUT_EN` -> one word, 0x44332211.
  - Without it -> one word, 0x2211BBAA.
- `sys_rst` pulsed during the second byte of a word -> all outputs 0; the next four full frames form one correct word.
